// File: rtl/serial_paralell.sv
`default_nettype none
// ============================================================================
// Module   : serial_paralell
// Desc     : I2S-style receiver. Deserialises left-justified, MSB-first
//            left/right words and presents each complete pair with a strobe.
// Revision : 1.0
// ============================================================================
module serial_paralell #(
    parameter int DATA_W      = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_12M,
    input  logic              rst,
    input  logic              start,
    input  logic              bclk,
    input  logic              lrclk,
    input  logic              data_serial,
    output logic [DATA_W-1:0] data_left,
    output logic [DATA_W-1:0] data_right,
    output logic              sample_valid,
    output logic              frame_err
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_LEFT_SHIFT  = 3'd1,
        ST_LEFT_WAIT   = 3'd2,
        ST_RIGHT_SHIFT = 3'd3,
        ST_RIGHT_WAIT  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [SYNC_STAGES-1:0] r_bclk_sync;
    logic [SYNC_STAGES-1:0] r_lr_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_bclk_d;
    logic                   r_lr_d;
    logic [DATA_W-2:0]      r_sr;
    logic [DATA_W-1:0]      r_left_hold;
    logic [CNT_W-1:0]       r_cnt;

    logic              w_bclk_s;
    logic              w_lr_s;
    logic              w_data_s;
    logic              w_bclk_rise;
    logic              w_lr_rise;
    logic              w_lr_fall;
    logic              w_lr_edge;
    logic              w_take;
    logic              w_last;
    logic [DATA_W-1:0] w_word;
    logic              w_clr;
    logic              w_shift;
    logic              w_ld_left;
    logic              w_ld_out;
    logic              w_err;

    assign w_bclk_s    = r_bclk_sync[SYNC_STAGES-1];
    assign w_lr_s      = r_lr_sync[SYNC_STAGES-1];
    assign w_data_s    = r_data_sync[SYNC_STAGES-1];
    assign w_bclk_rise = w_bclk_s & ~r_bclk_d;
    assign w_lr_rise   = w_lr_s & ~r_lr_d;
    assign w_lr_fall   = ~w_lr_s & r_lr_d;
    assign w_lr_edge   = w_lr_rise | w_lr_fall;
    // A bit clock edge coincident with a word-select edge belongs to neither word.
    assign w_take      = w_bclk_rise & ~w_lr_edge;
    assign w_last      = (r_cnt == c_LAST);
    assign w_word      = {r_sr, w_data_s};

    always_ff @(posedge clk_12M or posedge rst) begin
        if (rst) begin
            r_bclk_sync <= '0;
            r_lr_sync   <= '0;
            r_data_sync <= '0;
            r_bclk_d    <= 1'b0;
            r_lr_d      <= 1'b0;
        end else begin
            r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], bclk};
            r_lr_sync   <= {r_lr_sync[SYNC_STAGES-2:0], lrclk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], data_serial};
            r_bclk_d    <= w_bclk_s;
            r_lr_d      <= w_lr_s;
        end
    end

    always_ff @(posedge clk_12M or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_clr     = 1'b0;
        w_shift   = 1'b0;
        w_ld_left = 1'b0;
        w_ld_out  = 1'b0;
        w_err     = 1'b0;
        if (!start) begin
            w_next = ST_IDLE;
            w_clr  = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_lr_rise) begin
                        w_next = ST_LEFT_SHIFT;
                        w_clr  = 1'b1;
                    end
                end
                ST_LEFT_SHIFT: begin
                    if (w_lr_edge) begin
                        w_err  = 1'b1;
                        w_clr  = 1'b1;
                        w_next = w_lr_rise ? ST_LEFT_SHIFT : ST_IDLE;
                    end else if (w_take) begin
                        w_shift = 1'b1;
                        if (w_last) begin
                            w_ld_left = 1'b1;
                            w_next    = ST_LEFT_WAIT;
                        end
                    end
                end
                ST_LEFT_WAIT: begin
                    if (w_lr_edge) begin
                        w_next = ST_RIGHT_SHIFT;
                        w_clr  = 1'b1;
                    end
                end
                ST_RIGHT_SHIFT: begin
                    if (w_lr_edge) begin
                        w_err  = 1'b1;
                        w_clr  = 1'b1;
                        w_next = w_lr_rise ? ST_LEFT_SHIFT : ST_IDLE;
                    end else if (w_take) begin
                        w_shift = 1'b1;
                        if (w_last) begin
                            w_ld_out = 1'b1;
                            w_next   = ST_RIGHT_WAIT;
                        end
                    end
                end
                ST_RIGHT_WAIT: begin
                    if (w_lr_edge) begin
                        w_next = ST_LEFT_SHIFT;
                        w_clr  = 1'b1;
                    end
                end
                default: begin
                    w_next = ST_IDLE;
                    w_clr  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_12M or posedge rst) begin
        if (rst) begin
            r_sr         <= '0;
            r_cnt        <= '0;
            r_left_hold  <= '0;
            data_left    <= '0;
            data_right   <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            sample_valid <= w_ld_out;
            frame_err    <= w_err;
            if (w_clr) begin
                r_cnt <= '0;
                r_sr  <= '0;
            end else if (w_shift) begin
                r_cnt <= r_cnt + 1'b1;
                r_sr  <= w_word[DATA_W-2:0];
            end
            if (w_err) begin
                r_left_hold <= '0;
            end else if (w_ld_left) begin
                r_left_hold <= w_word;
            end
            if (w_ld_out) begin
                data_left  <= r_left_hold;
                data_right <= w_word;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_paralell.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_paralell
// Desc     : Randomised scoreboard bench for the serial_paralell receiver.
// Revision : 1.0
// ============================================================================
module tb_serial_paralell;
    localparam int DW = 24;

    logic          clk_12M = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          bclk = 1'b0;
    logic          lrclk = 1'b0;
    logic          data_serial = 1'b0;
    logic [DW-1:0] data_left;
    logic [DW-1:0] data_right;
    logic          sample_valid;
    logic          frame_err;

    serial_paralell #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
        .clk_12M      (clk_12M),
        .rst          (rst),
        .start        (start),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .data_serial  (data_serial),
        .data_left    (data_left),
        .data_right   (data_right),
        .sample_valid (sample_valid),
        .frame_err    (frame_err)
    );

    always #5 clk_12M = ~clk_12M;

    int n_checks = 0;
    int n_pass   = 0;
    int err_seen = 0;
    int exp_err  = 0;

    logic [2*DW-1:0] exp_q[$];
    logic            m_have_left = 1'b0;
    logic [DW-1:0]   m_left = '0;
    logic [2*DW-1:0] last_out = '0;

    task automatic check(input string nm, input logic [2*DW-1:0] got, input logic [2*DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
    endtask

    // Protocol-level model: a left word is held once complete; a right word
    // completes the pair only if a held left word exists. Short words that are
    // ended by an lrclk edge count as errors only while a word is being taken.
    function automatic void model_seg(input bit lr, input logic [DW-1:0] w, input int n, input bit aborted);
        if (aborted) begin
            m_have_left = 1'b0;
        end else if (lr) begin
            if (n >= DW) begin
                m_left      = w;
                m_have_left = 1'b1;
            end else begin
                m_have_left = 1'b0;
                exp_err++;
            end
        end else begin
            if (m_have_left) begin
                if (n >= DW) exp_q.push_back({m_left, w});
                else exp_err++;
            end
            m_have_left = 1'b0;
        end
    endfunction

    task automatic send_bit(input logic b);
        data_serial = b;
        bclk = 1'b0;
        repeat (2) @(negedge clk_12M);
        bclk = 1'b1;
        repeat (2) @(negedge clk_12M);
    endtask

    task automatic send_channel(input bit lr, input logic [DW-1:0] w, input int n,
                                input int extra, input bit aborted);
        model_seg(lr, w, n, aborted);
        lrclk = lr;
        for (int i = 0; i < n; i++) send_bit(w[DW-1-i]);
        for (int i = 0; i < extra; i++) send_bit(1'($urandom));
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int extra);
        send_channel(1'b1, l, DW, extra, 1'b0);
        send_channel(1'b0, r, DW, extra, 1'b0);
    endtask

    // Monitor: pops the scoreboard on every strobe, otherwise outputs must hold.
    always @(negedge clk_12M) begin
        if (rst) begin
            last_out = '0;
        end else begin
            if (frame_err) err_seen++;
            if (sample_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {data_left, data_right}, last_out);
                end else begin
                    check("pair", {data_left, data_right}, exp_q.pop_front());
                end
                last_out = {data_left, data_right};
            end else begin
                check("hold", {data_left, data_right}, last_out);
            end
        end
    end

    initial begin
        logic [DW-1:0] l, r;
        int nl, nr, el, er;

        repeat (3) @(negedge clk_12M);
        check("rst_outputs", {data_left, data_right}, '0);
        check("rst_flags", {46'd0, sample_valid, frame_err}, '0);
        rst = 1'b0;
        @(negedge clk_12M);
        start = 1'b1;

        // Stream joins mid-right-channel: nothing until the first full pair.
        send_channel(1'b0, 24'($urandom), 16, 0, 1'b0);
        send_frame(24'hA5A5A5, 24'h5A5A5A, 0);
        repeat (8) @(negedge clk_12M);
        check("first_pair_taken", 48'(exp_q.size()), 48'd0);
        check("no_err_first", 48'(err_seen), 48'd0);

        send_frame(24'h123456, 24'h654321, 10);
        send_frame(24'h800000, 24'h7FFFFF, 10);
        send_frame(24'h000001, 24'hFFFFFE, 10);

        // Short left word.
        send_channel(1'b1, 24'($urandom), 20, 0, 1'b0);
        send_channel(1'b0, 24'($urandom), DW, 0, 1'b0);
        send_frame(24'($urandom), 24'($urandom), 3);
        repeat (8) @(negedge clk_12M);
        check("short_left_err", 48'(err_seen), 48'(exp_err));

        // Reset in the middle of a right word.
        send_channel(1'b1, 24'($urandom), DW, 2, 1'b0);
        send_channel(1'b0, 24'($urandom), 12, 0, 1'b1);
        @(posedge clk_12M);
        #2 rst = 1'b1;
        #1;
        check("midword_rst_outputs", {data_left, data_right}, '0);
        check("midword_rst_flags", {46'd0, sample_valid, frame_err}, '0);
        repeat (3) @(negedge clk_12M);
        rst = 1'b0;
        @(negedge clk_12M);
        send_frame(24'h0F0F0F, 24'hF0F0F0, 0);

        // start dropped after 10 left bits, restored during the right word.
        l = 24'($urandom);
        send_channel(1'b1, l, 10, 0, 1'b1);
        start = 1'b0;
        for (int i = 10; i < DW; i++) send_bit(l[DW-1-i]);
        send_channel(1'b0, 24'($urandom), 8, 0, 1'b1);
        start = 1'b1;
        for (int i = 0; i < 16; i++) send_bit(1'($urandom));
        send_frame(24'($urandom), 24'($urandom), 0);
        repeat (8) @(negedge clk_12M);
        check("start_drop_err", 48'(err_seen), 48'(exp_err));

        // Randomised frames with occasional short words.
        for (int k = 0; k < 10; k++) begin
            l  = 24'($urandom);
            r  = 24'($urandom);
            nl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, DW - 1)) : DW;
            nr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, DW - 1)) : DW;
            el = (nl == DW) ? int'($urandom_range(0, 10)) : 0;
            er = (nr == DW) ? int'($urandom_range(0, 10)) : 0;
            send_channel(1'b1, l, nl, el, 1'b0);
            send_channel(1'b0, r, nr, er, 1'b0);
        end
        send_frame(24'($urandom), 24'($urandom), 2);

        repeat (20) @(negedge clk_12M);
        check("queue_drained", 48'(exp_q.size()), 48'd0);
        check("frame_err_count", 48'(err_seen), 48'(exp_err));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/serial_paralell.md
Name: serial_paralell

Overview:
- I2S-style receiver; the capture-side counterpart of the codec-facing parallel-to-serial transmitter.
- Samples external bclk/lrclk/data_serial in the clk_12M domain and deserialises left-justified 24-bit MSB-first words.
- Channel mapping: lrclk=1 is left, lrclk=0 is right.
- Presents each completed left/right pair as parallel words with a one-cycle valid strobe, for the FIR filter input path.

Parameters:
- DATA_W, 24, bits per channel word.
- SYNC_STAGES, 2, synchroniser flops on each serial input; must be >= 2.

Ports:
- clk_12M  input  1  system clock; all logic is on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level enable; low forces IDLE and discards any partial word.
- bclk  input  1  serial bit clock; high and low phases each >= 1 clk_12M cycle.
- lrclk  input  1  word select; 1 = left, 0 = right.
- data_serial  input  1  serial data, sampled on bclk rising edges.
- data_left  output  DATA_W  last complete left word.
- data_right  output  DATA_W  last complete right word.
- sample_valid  output  1  one-cycle pulse when data_left/data_right update.
- frame_err  output  1  one-cycle pulse on a short word.

Behaviour:
- Reset:
  - Asynchronous; all state clears: state=IDLE, shift register=0, left hold=0, bit counter=0, synchroniser and edge flops=0.
  - Outputs: data_left=0, data_right=0, sample_valid=0, frame_err=0.
- Synchronisation:
  - bclk, lrclk and data_serial each pass through SYNC_STAGES flops; all three have equal depth so they stay aligned.
  - One extra delay flop per clock gives edge detects: bclk_rise = bclk_s & ~bclk_d; lr_rise / lr_fall from lrclk_s and lrclk_d.
- Bit capture:
  - A bit is taken on bclk_rise only: shift register <= {sr[DATA_W-2:0], data_s}, bit counter +1.
  - A bclk_rise in the same cycle as an lrclk edge is ignored; the first captured bit is the first bclk_rise strictly after the lrclk edge, and it is the MSB.
- States:
  - IDLE: wait for lr_rise with start=1, then go to LEFT_SHIFT with counter=0. lr_fall is ignored.
  - LEFT_SHIFT: capture bits. On the DATA_W-th bit, copy {sr, bit} into the left hold register and go to LEFT_WAIT.
  - LEFT_WAIT: ignore extra bclk edges. On lr_fall go to RIGHT_SHIFT with counter=0.
  - RIGHT_SHIFT: capture bits. On the DATA_W-th bit, at that same clock edge: data_left<=left hold, data_right<={sr[DATA_W-2:0], data_s}, sample_valid<=1 for one cycle; go to RIGHT_WAIT.
  - RIGHT_WAIT: ignore extra bclk edges. On lr_rise go to LEFT_SHIFT with counter=0.
- Latency: pin-level 24th right-bit bclk rising edge to sample_valid high is SYNC_STAGES+1 clk_12M cycles (3 at default).
- Short word:
  - Trigger: an lrclk edge in LEFT_SHIFT or RIGHT_SHIFT before DATA_W bits.
  - Response: frame_err pulses 1 cycle, the partial word and any held left word are discarded, and no sample_valid is produced for that pair.
  - Next state: if the offending edge is lr_rise, go to LEFT_SHIFT (counter=0); otherwise go to IDLE.
- Wrong-direction edge in a WAIT state (e.g. lr_rise in LEFT_WAIT): cannot occur with a single lrclk. If a glitch produces one, treat it as the correct edge for that state.
- Outputs hold their values between sample_valid pulses; they never show partial data.
- start deasserted mid-word: next cycle state=IDLE, counter=0, no strobe. Outputs keep their last pair.
- Reset mid-word: all registers clear immediately, regardless of clock.
- Simultaneous DATA_W-th bclk_rise and lrclk edge: the bclk edge is ignored per the capture rule, so this counts as a short word and frame_err fires.

Test Plan:
- Reset then start=1; drive left=24'hA5A5A5, right=24'h5A5A5A, MSB-first, bclk = 4 clk_12M cycles per period -> exactly one sample_valid pulse; data_left=A5A5A5, data_right=5A5A5A; frame_err never asserted.
- Three back-to-back frames (123456/654321, 800000/7FFFFF, 000001/FFFFFE) with 10 extra bclk edges per channel -> three strobes with matching values; extra edges ignored; outputs stable between strobes.
- Stream starting mid-right-channel (lrclk=0 at start) -> no strobe until the first full left+right pair after the first lrclk rise.
- lrclk falls after 20 left bits -> one frame_err pulse, no strobe, state IDLE; the next full frame is captured correctly.
- Assert rst at 12 bits into the right word, release, send frame 0F0F0F/F0F0F0 -> outputs 0 immediately at reset; one strobe later with the new values.
- Drop start after 10 left bits, raise it again before the next lrclk rise -> no strobe and no frame_err for the aborted frame; the following frame is captured correctly.
